rat_regfile: RTL and testbench
==============================

// Module: rat_regfile
// PURPOSE
//   Architectural register file plus rename table (busy bit + producing ROB tag per register).
//   - Dispatch side: sets busy/tag for each newly dispatched destination register.
//   - Commit side: writes retired values from the ROB head and clears busy when the tag matches.
//   - Read side: supplies value or producing tag for rs1/rs2 to the dispatching instruction.
//   - Sits directly downstream of the ROB; consumes its regf_we, rd_s1/rd_s2, rd_v and rob_tag1/rob_tag2.
// PARAMETERS
//   NUM_REGS   32  architectural integer registers; x0 is hardwired to zero
//   ROB_DEPTH  32  ROB entries
//   TAG_W      $clog2(ROB_DEPTH)  ROB tag width (5 by default)
// PORTS
//   clk          in   1      clock; all state updates on posedge
//   rst          in   1      synchronous, active-high reset
//   flush        in   1      branch_mispredicted: ROB is being cleared this cycle
//   disp_we      in   1      dispatch allocates rd (ROB regf_we[0])
//   disp_rd      in   5      dispatch destination (ROB rd_s2)
//   disp_tag     in   TAG_W  ROB tag allocated to disp_rd (ROB rob_tag2)
//   commit_we    in   1      head retires with reg write (ROB regf_we[1])
//   commit_rd    in   5      retiring destination (ROB rd_s1)
//   commit_value in   32     retiring value (ROB rd_v)
//   commit_tag   in   TAG_W  tag of retiring entry (ROB rob_tag1)
//   rs1_s, rs2_s in   5      source register indices of dispatching instruction
//   rs1_v, rs2_v out  32     register value (valid when *_busy = 0)
//   rs1_busy, rs2_busy out 1 source still pending in ROB
//   rs1_tag, rs2_tag   out TAG_W  producing ROB tag (valid when *_busy = 1)
// BEHAVIOUR
//   - Reset: all data = 0, busy = 0, tags = 0. Reads after reset return 0 / not busy / tag 0.
//   - Reads are combinational, 0-cycle latency. Order of evaluation:
//     - index 0: v = 0, busy = 0, tag = 0.
//     - commit bypass: commit_we && commit_rd == rs && commit_rd != 0 && commit_tag == tag[rs] && busy[rs]
//       -> v = commit_value, busy = 0.
//     - otherwise: v = data[rs], busy = busy[rs], tag = tag[rs].
//     - Same-cycle dispatch never affects same-cycle reads (sources are read before own rd is renamed).
//   - Commit (posedge, commit_we && commit_rd != 0):
//     - data[commit_rd] <= commit_value unconditionally.
//     - busy[commit_rd] <= 0 only if tag[commit_rd] == commit_tag; a younger in-flight producer keeps busy.
//   - Dispatch (posedge, disp_we && disp_rd != 0 && !flush): busy[disp_rd] <= 1, tag[disp_rd] <= disp_tag.
//   - Dispatch and commit to the same rd in one cycle:
//     - data takes commit_value;
//     - busy = 1 and tag = disp_tag (dispatch wins).
//   - Flush (posedge):
//     - all busy <= 0;
//     - a concurrent commit still writes data (e.g. JAL/JALR link of the retiring branch);
//     - concurrent dispatch is ignored;
//     - data of all other registers is retained.
//   - rst has priority over flush, commit and dispatch. Reset asserted mid-operation clears state on the next edge.
//   - x0: never written, never busy, regardless of inputs.
//   - Tags are opaque; no wrap-around arithmetic is performed on them (equality compare only).
// STRUCTURE
//   - rv32i_types: TAG_W-derived rob_tag_t typedef shared with the ROB and reservation stations;
//     rat_entry_t {busy, tag} struct.
//   - Single module, no sub-modules; read logic duplicated per source port via a function.
// TESTING
//   1 reset, read x5 -> rs1_v = 0, rs1_busy = 0; read x0 after commit to x0 of 0xDEAD -> 0, not busy.
//   2 dispatch x3 tag 7; next cycle read x3 -> busy = 1, tag = 7; commit x3 tag 7 value 0x1234
//     -> same-cycle bypass v = 0x1234, busy = 0; next cycle data = 0x1234, not busy.
//   3 dispatch x4 tag 2, then x4 tag 9; commit x4 tag 2 value 0x55 -> data = 0x55, busy = 1, tag = 9.
//   4 same cycle dispatch x6 tag 11 and commit x6 (tag 11 old) value 0xAA
//     -> after edge: data = 0xAA, busy = 1, tag = 11.
//   5 x1, x2 busy; flush with commit x1 value 0x80 and dispatch x2 tag 3
//     -> after edge: x1 = 0x80, no register busy, x2 data unchanged.
//   6 dispatch x7 tag 1 while rs1_s = x7 -> rs1 reads old value, not busy, in that cycle.

Source files
------------

// File: rtl/rat_regfile_pkg.sv
// rat_regfile_pkg: shared ROB tag type and rename-table entry for the register file.
package rat_regfile_pkg;
  localparam int NUM_REGS = 32;
  localparam int ROB_DEPTH = 32;
  localparam int TAG_W = $clog2(ROB_DEPTH);
  typedef logic [TAG_W-1:0] rob_tag_t;
  typedef struct packed {
    logic busy;
    rob_tag_t tag;
  } rat_entry_t;
  typedef struct packed {
    logic [31:0] value;
    logic busy;
    rob_tag_t tag;
  } rd_res_t;
endpackage

// File: rtl/rat_regfile.sv
// rat_regfile: architectural register file with busy/tag rename table and commit bypass.
module rat_regfile
  import rat_regfile_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic disp_we,
  input  logic [4:0] disp_rd,
  input  logic [TAG_W-1:0] disp_tag,
  input  logic commit_we,
  input  logic [4:0] commit_rd,
  input  logic [31:0] commit_value,
  input  logic [TAG_W-1:0] commit_tag,
  input  logic [4:0] rs1_s,
  input  logic [4:0] rs2_s,
  output logic [31:0] rs1_v,
  output logic [31:0] rs2_v,
  output logic rs1_busy,
  output logic rs2_busy,
  output logic [TAG_W-1:0] rs1_tag,
  output logic [TAG_W-1:0] rs2_tag
);
  logic [31:0] data [NUM_REGS];
  rat_entry_t rat [NUM_REGS];
  rd_res_t r1, r2;
  function automatic rd_res_t rd_port(input logic [4:0] rs, input logic [31:0] d, input rat_entry_t e,
                                      input logic cwe, input logic [4:0] crd, input logic [31:0] cv,
                                      input rob_tag_t ct);
    rd_res_t r;
    r = '{value: d, busy: e.busy, tag: e.tag};
    if (cwe && crd == rs && crd != 5'd0 && ct == e.tag && e.busy) begin
      r.value = cv;
      r.busy = 1'b0;
    end
    return rs == 5'd0 ? '0 : r;
  endfunction
  always_comb begin
    r1 = rd_port(rs1_s, data[rs1_s], rat[rs1_s], commit_we, commit_rd, commit_value, commit_tag);
    r2 = rd_port(rs2_s, data[rs2_s], rat[rs2_s], commit_we, commit_rd, commit_value, commit_tag);
  end
  assign {rs1_v, rs1_busy, rs1_tag} = r1;
  assign {rs2_v, rs2_busy, rs2_tag} = r2;
  // Later assignments win: flush clears busy after commit, dispatch overrides commit's clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        data[i] <= '0;
        rat[i] <= '0;
      end
    end else begin
      if (commit_we && commit_rd != 5'd0) begin
        data[commit_rd] <= commit_value;
        if (rat[commit_rd].tag == commit_tag) rat[commit_rd].busy <= 1'b0;
      end
      if (flush) begin
        for (int i = 0; i < NUM_REGS; i++) rat[i].busy <= 1'b0;
      end else if (disp_we && disp_rd != 5'd0) begin
        rat[disp_rd] <= '{busy: 1'b1, tag: disp_tag};
      end
    end
  end
endmodule

// File: tb/tb_rat_regfile.sv
// tb_rat_regfile: table-driven directed check of rat_regfile reads, commit, dispatch, flush and reset.
module tb_rat_regfile;
  import rat_regfile_pkg::*;
  logic clk = 1'b0;
  logic rst, flush, disp_we, commit_we;
  logic [4:0] disp_rd, commit_rd, rs1_s, rs2_s;
  logic [TAG_W-1:0] disp_tag, commit_tag, rs1_tag, rs2_tag;
  logic [31:0] commit_value, rs1_v, rs2_v;
  logic rs1_busy, rs2_busy;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rat_regfile dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_we(disp_we), .disp_rd(disp_rd), .disp_tag(disp_tag),
    .commit_we(commit_we), .commit_rd(commit_rd), .commit_value(commit_value), .commit_tag(commit_tag),
    .rs1_s(rs1_s), .rs2_s(rs2_s),
    .rs1_v(rs1_v), .rs2_v(rs2_v), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_tag(rs1_tag), .rs2_tag(rs2_tag)
  );

  typedef struct {
    logic fl;
    logic dwe;
    logic [4:0] drd;
    logic [4:0] dtag;
    logic cwe;
    logic [4:0] crd;
    logic [31:0] cval;
    logic [4:0] ctag;
    logic [4:0] r1;
    logic [4:0] r2;
    logic [31:0] e1v;
    logic e1b;
    logic [4:0] e1t;
    logic [31:0] e2v;
    logic e2b;
    logic [4:0] e2t;
  } vec_t;

  vec_t vt [20];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    flush = v.fl; disp_we = v.dwe; disp_rd = v.drd; disp_tag = v.dtag;
    commit_we = v.cwe; commit_rd = v.crd; commit_value = v.cval; commit_tag = v.ctag;
    rs1_s = v.r1; rs2_s = v.r2;
  endtask

  task automatic idle();
    flush = 0; disp_we = 0; disp_rd = 0; disp_tag = 0;
    commit_we = 0; commit_rd = 0; commit_value = 0; commit_tag = 0;
  endtask

  initial begin
    //          fl dwe drd dtag cwe crd cval          ctag r1 r2  e1v           e1b e1t e2v           e2b e2t
    vt[0]  = '{0, 0,  0,  0,   0,  0,  32'h0,        0,   5, 0,  32'h0,        0,  0,  32'h0,        0,  0};
    vt[1]  = '{0, 0,  0,  0,   1,  0,  32'hDEAD,     0,   0, 5,  32'h0,        0,  0,  32'h0,        0,  0};
    vt[2]  = '{0, 0,  0,  0,   0,  0,  32'h0,        0,   0, 3,  32'h0,        0,  0,  32'h0,        0,  0};
    vt[3]  = '{0, 1,  3,  7,   0,  0,  32'h0,        0,   3, 0,  32'h0,        0,  0,  32'h0,        0,  0};
    vt[4]  = '{0, 0,  0,  0,   0,  0,  32'h0,        0,   3, 3,  32'h0,        1,  7,  32'h0,        1,  7};
    vt[5]  = '{0, 0,  0,  0,   1,  3,  32'h1234,     7,   3, 3,  32'h1234,     0,  7,  32'h1234,     0,  7};
    vt[6]  = '{0, 0,  0,  0,   0,  0,  32'h0,        0,   3, 0,  32'h1234,     0,  7,  32'h0,        0,  0};
    vt[7]  = '{0, 1,  4,  2,   0,  0,  32'h0,        0,   4, 3,  32'h0,        0,  0,  32'h1234,     0,  7};
    vt[8]  = '{0, 1,  4,  9,   0,  0,  32'h0,        0,   4, 0,  32'h0,        1,  2,  32'h0,        0,  0};
    vt[9]  = '{0, 0,  0,  0,   1,  4,  32'h55,       2,   4, 0,  32'h0,        1,  9,  32'h0,        0,  0};
    vt[10] = '{0, 0,  0,  0,   0,  0,  32'h0,        0,   4, 3,  32'h55,       1,  9,  32'h1234,     0,  7};
    vt[11] = '{0, 1,  6,  11,  0,  0,  32'h0,        0,   6, 0,  32'h0,        0,  0,  32'h0,        0,  0};
    vt[12] = '{0, 1,  6,  11,  1,  6,  32'hAA,       11,  6, 0,  32'hAA,       0,  11, 32'h0,        0,  0};
    vt[13] = '{0, 0,  0,  0,   0,  0,  32'h0,        0,   6, 0,  32'hAA,       1,  11, 32'h0,        0,  0};
    vt[14] = '{0, 1,  1,  4,   1,  2,  32'h22,       0,   1, 2,  32'h0,        0,  0,  32'h0,        0,  0};
    vt[15] = '{0, 1,  2,  5,   0,  0,  32'h0,        0,   1, 2,  32'h0,        1,  4,  32'h22,       0,  0};
    vt[16] = '{1, 1,  2,  3,   1,  1,  32'h80,       4,   1, 2,  32'h80,       0,  4,  32'h22,       1,  5};
    vt[17] = '{0, 1,  0,  6,   0,  0,  32'h0,        0,   1, 2,  32'h80,       0,  0,  32'h22,       0,  0};
    vt[18] = '{0, 0,  0,  0,   0,  0,  32'h0,        0,   4, 6,  32'h55,       0,  0,  32'hAA,       0,  0};
    vt[19] = '{0, 0,  0,  0,   0,  0,  32'h0,        0,   0, 0,  32'h0,        0,  0,  32'h0,        0,  0};
    idle();
    rs1_s = 0; rs2_s = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 20; i++) begin
      drive(vt[i]);
      #1;
      check("rs1_v", i, rs1_v, vt[i].e1v);
      check("rs1_busy", i, 32'(rs1_busy), 32'(vt[i].e1b));
      if (vt[i].e1b) check("rs1_tag", i, 32'(rs1_tag), 32'(vt[i].e1t));
      check("rs2_v", i, rs2_v, vt[i].e2v);
      check("rs2_busy", i, 32'(rs2_busy), 32'(vt[i].e2b));
      if (vt[i].e2b) check("rs2_tag", i, 32'(rs2_tag), 32'(vt[i].e2t));
      @(negedge clk);
    end
    // Commit with a stale tag to an idle register still writes data.
    idle();
    commit_we = 1; commit_rd = 9; commit_value = 32'hBEEF; commit_tag = 13;
    rs1_s = 9; rs2_s = 0;
    @(negedge clk);
    idle();
    #1;
    check("stale_commit_v", 0, rs1_v, 32'hBEEF);
    check("stale_commit_busy", 0, 32'(rs1_busy), 32'd0);
    // Reset mid-operation with a concurrent dispatch clears everything.
    disp_we = 1; disp_rd = 9; disp_tag = 3;
    @(negedge clk);
    idle();
    rs1_s = 9; rs2_s = 6;
    #1;
    check("pre_rst_busy", 0, 32'(rs1_busy), 32'd1);
    check("pre_rst_tag", 0, 32'(rs1_tag), 32'd3);
    rst = 1; disp_we = 1; disp_rd = 6; disp_tag = 8;
    commit_we = 1; commit_rd = 9; commit_value = 32'h77; commit_tag = 3;
    @(negedge clk);
    rst = 0;
    idle();
    #1;
    check("rst_v", 0, rs1_v, 32'h0);
    check("rst_busy", 0, 32'(rs1_busy), 32'd0);
    check("rst_tag", 0, 32'(rs1_tag), 32'd0);
    check("rst_v", 1, rs2_v, 32'h0);
    check("rst_busy", 1, 32'(rs2_busy), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
